cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- FSM sequencing the direct-mapped write-back `cache` datapath between one CPU port and a word-wide memory port.
- Hits complete with zero wait cycles. On a miss the controller writes back a dirty victim line, refills the line from memory, then replays the request so it hits.
- Sits between the core's load/store unit and the external memory interface.

Parameters:
TAG_W, 22, tag width; equals 32 - IDX_W - OFF_W - 2
IDX_W, 6, index bits (64 lines), addr[9:4]
OFF_W, 2, word-offset bits (4 words/line), addr[3:2]

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
cpu_req  in  1  request valid; held with addr/we/din until cpu_ready
cpu_we  in  1  1=store, 0=load
cpu_addr  in  32  byte address, word-aligned
cpu_din  in  32  store data
cpu_dout  out  32  load data, valid when cpu_ready & ~cpu_we
cpu_ready  out  1  request completes this cycle
cache_addr  out  32  to cache addr
cache_store  out  1  fill write; cache sets valid, clears dirty, loads tag
cache_edit  out  1  CPU write; cache sets dirty
cache_invalid  out  1  clear valid of addressed line
cache_din  out  32  to cache din
cache_hit  in  1  combinational hit for cache_addr
cache_dout  in  32  combinational read data
cache_valid  in  1  line valid
cache_dirty  in  1  line dirty
cache_tag  in  TAG_W  stored tag of addressed line
mem_cs  out  1  memory request
mem_we  out  1  memory write
mem_addr  out  32  word address (byte-addressed, [1:0]=0)
mem_dout  out  32  write data to memory
mem_din  in  32  read data from memory
mem_ack  in  1  one-cycle completion of current memory word

Behaviour:
- Cache reads are combinational; cache writes take effect on the clk edge.
- Reset (rst=0, async): state IDLE, word counter 0. cpu_ready, cache_store, cache_edit, cache_invalid, mem_cs and mem_we are 0. All data/address outputs are 0.
- Reset mid-operation aborts any burst immediately, with mem_cs dropping asynchronously. A partially filled line is not repaired; the CPU must re-issue.
- States: IDLE, WB, FILL.
- IDLE:
  - cache_addr = cpu_addr.
  - Load hit: cpu_ready=1 and cpu_dout=cache_dout in the same cycle.
  - Store hit: cache_edit=1, cache_din=cpu_din, cpu_ready=1 in the same cycle.
  - Miss (cpu_req & ~cache_hit): latch cpu_addr, then go to WB if cache_valid & cache_dirty, otherwise to FILL. Counter cleared.
- WB: victim address = {latched victim tag, index, cnt, 2'b00}.
  - cache_addr = victim address; mem_cs=1, mem_we=1, mem_addr = victim address, mem_dout=cache_dout.
  - The victim tag is captured from cache_tag on IDLE exit.
  - On mem_ack: cnt++. After word 3 ack: cnt=0, go to FILL.
- FILL:
  - mem_cs=1, mem_we=0, mem_addr = {req tag, index, cnt, 2'b00}.
  - On mem_ack: cache_store=1, cache_addr=mem_addr, cache_din=mem_din, cnt++.
  - After word 3 ack: go to IDLE, where the held request now hits.
- Miss penalty: 4 acks for a clean miss, 8 acks for a dirty miss, plus the replay cycle.
- Words are always transferred in order 0..3; no critical-word-first.
- mem_* outputs are held stable until mem_ack. mem_ack outside WB/FILL is ignored.
- cpu_ready is never asserted outside IDLE.
- cpu_req dropping mid-miss: the line operation completes and nothing is replayed.

Optional Feature:
- CACHE_CTRL_FLUSH_EN defined:
  - Adds ports flush_req (in, 1) and flush_done (out, 1, reset 0), plus state FLUSH.
  - In IDLE, flush_req has priority over cpu_req.
  - FLUSH walks index 0..63. For each index, probe {index, 4'b0}:
    - valid & dirty: write back all 4 words as in WB, then one cycle of cache_invalid=1.
    - valid & clean: cache_invalid=1 only.
    - not valid: skip.
  - After index 63: flush_done pulses 1 cycle and the FSM returns to IDLE.
- Undefined: no flush ports, no FLUSH state.

Test Plan:
- Memory model returns data = mem_addr, mem_ack 1 cycle after mem_cs.
- Load 0x14 into an empty cache -> 4 reads at 0x10,0x14,0x18,0x1C with 4 cache_store pulses -> cpu_ready, cpu_dout=0x0000_0014.
- Load 0x18 next -> cpu_ready the same cycle, dout=0x0000_0018, mem_cs stays 0.
- Store 0x18 din=0x2222_2222 -> one cache_edit pulse, cpu_ready -> reload 0x18 returns 0x2222_2222, cache_dirty=1.
- Load 0x418 (index 1, tag differs) -> writes 0x10..0x1C with data 0x10, 0x14, 0x2222_2222, 0x1C, then reads 0x410..0x41C -> dout=0x0000_0418.
- mem_ack delayed 3 cycles per word -> mem_addr/mem_dout stable across waits. Assert rst=0 after the second FILL ack -> mem_cs=0 immediately, IDLE. After release, re-issue completes correctly.
- [CACHE_CTRL_FLUSH_EN] dirty line at index 1, clean at 2, flush_req=1 -> writeback 0x410..0x41C then invalidate index 1, invalidate index 2, flush_done pulse after index 63. Load 0x418 afterwards misses.

Source files
------------

// File: rtl/cache_ctrl.sv
// cache_ctrl: controller for a direct-mapped write-back cache with a word-wide memory port.
// Optional CACHE_CTRL_FLUSH_EN adds a whole-cache flush walk (flush_req / flush_done).
module cache_ctrl #(
   parameter int TAG_W = 22,
   parameter int IDX_W = 6,
   parameter int OFF_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [31:0]      cpu_addr,
   input  logic [31:0]      cpu_din,
   output logic [31:0]      cpu_dout,
   output logic             cpu_ready,
   output logic [31:0]      cache_addr,
   output logic             cache_store,
   output logic             cache_edit,
   output logic             cache_invalid,
   output logic [31:0]      cache_din,
   input  logic             cache_hit,
   input  logic [31:0]      cache_dout,
   input  logic             cache_valid,
   input  logic             cache_dirty,
   input  logic [TAG_W-1:0] cache_tag,
   output logic             mem_cs,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_dout,
   input  logic [31:0]      mem_din,
   input  logic             mem_ack
`ifdef CACHE_CTRL_FLUSH_EN
   ,
   input  logic             flush_req,
   output logic             flush_done
`endif
);

   localparam int LINE_W = TAG_W + IDX_W;
   localparam int IDX_LO = OFF_W + 2;
   localparam logic [OFF_W-1:0] CNT_ZERO = {OFF_W{1'b0}};
   localparam logic [OFF_W-1:0] CNT_ONE  = {{(OFF_W-1){1'b0}}, 1'b1};
   localparam logic [OFF_W-1:0] CNT_LAST = {OFF_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WB    = 2'd1,
      ST_FILL  = 2'd2
`ifdef CACHE_CTRL_FLUSH_EN
      ,
      ST_FLUSH = 2'd3
`endif
   } state_t;

   state_t            state_r;
   logic [OFF_W-1:0]  cnt_r;
   logic [LINE_W-1:0] req_line_r;
   logic [TAG_W-1:0]  victim_tag_r;
   logic              mem_cs_r;
   logic              mem_we_r;
   logic [31:0]       mem_addr_r;

   logic              serve_s;
   logic [TAG_W-1:0]  req_tag_s;
   logic [IDX_W-1:0]  req_idx_s;
   logic [TAG_W-1:0]  cpu_tag_s;
   logic [IDX_W-1:0]  cpu_idx_s;

`ifdef CACHE_CTRL_FLUSH_EN
   localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};
   localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

   logic [IDX_W-1:0]  flush_idx_r;
   logic              fl_inv_r;
   logic              flushing_r;
   logic              flush_done_r;

   assign flush_done = flush_done_r;
   assign serve_s    = cpu_req & cache_hit & ~flush_req;
`else
   assign serve_s    = cpu_req & cache_hit;
`endif

   assign req_tag_s = req_line_r[LINE_W-1 -: TAG_W];
   assign req_idx_s = req_line_r[IDX_W-1:0];
   assign cpu_tag_s = cpu_addr[31 -: TAG_W];
   assign cpu_idx_s = cpu_addr[IDX_LO +: IDX_W];

   assign mem_cs   = mem_cs_r;
   assign mem_we   = mem_we_r;
   assign mem_addr = mem_addr_r;

   function automatic logic [31:0] word_addr(input logic [TAG_W-1:0] tag,
                                             input logic [IDX_W-1:0] idx,
                                             input logic [OFF_W-1:0] off);
      return {tag, idx, off, 2'b00};
   endfunction

   // FSM state, burst counter, latched request/victim line and the registered memory request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         cnt_r        <= CNT_ZERO;
         req_line_r   <= {LINE_W{1'b0}};
         victim_tag_r <= {TAG_W{1'b0}};
         mem_cs_r     <= 1'b0;
         mem_we_r     <= 1'b0;
         mem_addr_r   <= 32'd0;
`ifdef CACHE_CTRL_FLUSH_EN
         flush_idx_r  <= {IDX_W{1'b0}};
         fl_inv_r     <= 1'b0;
         flushing_r   <= 1'b0;
         flush_done_r <= 1'b0;
`endif
      end else begin
`ifdef CACHE_CTRL_FLUSH_EN
         flush_done_r <= 1'b0;
`endif
         case (state_r)
            ST_IDLE: begin
`ifdef CACHE_CTRL_FLUSH_EN
               if (flush_req) begin
                  state_r     <= ST_FLUSH;
                  flush_idx_r <= {IDX_W{1'b0}};
                  fl_inv_r    <= 1'b0;
                  flushing_r  <= 1'b1;
               end else
`endif
               if (cpu_req && !cache_hit) begin
                  req_line_r   <= cpu_addr[31 -: LINE_W];
                  victim_tag_r <= cache_tag;
                  cnt_r        <= CNT_ZERO;
                  mem_cs_r     <= 1'b1;
                  if (cache_valid && cache_dirty) begin
                     state_r    <= ST_WB;
                     mem_we_r   <= 1'b1;
                     mem_addr_r <= word_addr(cache_tag, cpu_idx_s, CNT_ZERO);
                  end else begin
                     state_r    <= ST_FILL;
                     mem_we_r   <= 1'b0;
                     mem_addr_r <= word_addr(cpu_tag_s, cpu_idx_s, CNT_ZERO);
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_WB: begin
               if (mem_ack) begin
                  if (cnt_r == CNT_LAST) begin
                     cnt_r <= CNT_ZERO;
`ifdef CACHE_CTRL_FLUSH_EN
                     if (flushing_r) begin
                        state_r    <= ST_FLUSH;
                        fl_inv_r   <= 1'b1;
                        mem_cs_r   <= 1'b0;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= 32'd0;
                     end else
`endif
                     begin
                        state_r    <= ST_FILL;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= word_addr(req_tag_s, req_idx_s, CNT_ZERO);
                     end
                  end else begin
                     cnt_r      <= cnt_r + CNT_ONE;
                     mem_addr_r <= word_addr(victim_tag_r, req_idx_s, cnt_r + CNT_ONE);
                  end
               end else begin
                  state_r <= ST_WB;
               end
            end
            ST_FILL: begin
               if (mem_ack) begin
                  if (cnt_r == CNT_LAST) begin
                     state_r    <= ST_IDLE;
                     cnt_r      <= CNT_ZERO;
                     mem_cs_r   <= 1'b0;
                     mem_addr_r <= 32'd0;
                  end else begin
                     cnt_r      <= cnt_r + CNT_ONE;
                     mem_addr_r <= word_addr(req_tag_s, req_idx_s, cnt_r + CNT_ONE);
                  end
               end else begin
                  state_r <= ST_FILL;
               end
            end
`ifdef CACHE_CTRL_FLUSH_EN
            ST_FLUSH: begin
               // Probe cycle decides per line; the invalidate cycle and skipped lines advance the walk.
               if (!fl_inv_r && cache_valid && cache_dirty) begin
                  state_r      <= ST_WB;
                  victim_tag_r <= cache_tag;
                  req_line_r   <= {{TAG_W{1'b0}}, flush_idx_r};
                  cnt_r        <= CNT_ZERO;
                  mem_cs_r     <= 1'b1;
                  mem_we_r     <= 1'b1;
                  mem_addr_r   <= word_addr(cache_tag, flush_idx_r, CNT_ZERO);
               end else if (!fl_inv_r && cache_valid) begin
                  fl_inv_r <= 1'b1;
               end else begin
                  fl_inv_r <= 1'b0;
                  if (flush_idx_r == IDX_LAST) begin
                     state_r      <= ST_IDLE;
                     flushing_r   <= 1'b0;
                     flush_done_r <= 1'b1;
                  end else begin
                     flush_idx_r <= flush_idx_r + IDX_ONE;
                  end
               end
            end
`endif
            default: begin
               state_r  <= ST_IDLE;
               cnt_r    <= CNT_ZERO;
               mem_cs_r <= 1'b0;
               mem_we_r <= 1'b0;
            end
         endcase
      end
   end

   // Cache-side and CPU-side strobes; hits are served in the request cycle
   always_comb begin
      cpu_dout      = 32'd0;
      cpu_ready     = 1'b0;
      cache_addr    = 32'd0;
      cache_store   = 1'b0;
      cache_edit    = 1'b0;
      cache_invalid = 1'b0;
      cache_din     = 32'd0;
      mem_dout      = 32'd0;
      case (state_r)
         ST_IDLE: begin
            if (rst) begin
               cache_addr = cpu_addr;
               if (serve_s) begin
                  cpu_ready = 1'b1;
                  if (cpu_we) begin
                     cache_edit = 1'b1;
                     cache_din  = cpu_din;
                  end else begin
                     cpu_dout = cache_dout;
                  end
               end else begin
                  cpu_ready = 1'b0;
               end
            end else begin
               cache_addr = 32'd0;
            end
         end
         ST_WB: begin
            cache_addr = mem_addr_r;
            mem_dout   = cache_dout;
         end
         ST_FILL: begin
            cache_addr = mem_addr_r;
            if (mem_ack) begin
               cache_store = 1'b1;
               cache_din   = mem_din;
            end else begin
               cache_store = 1'b0;
            end
         end
`ifdef CACHE_CTRL_FLUSH_EN
         ST_FLUSH: begin
            cache_addr    = {{TAG_W{1'b0}}, flush_idx_r, {IDX_LO{1'b0}}};
            cache_invalid = fl_inv_r;
         end
`endif
         default: begin
            cache_addr = 32'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: random load/store traffic against a flat-memory reference, scoreboard-checked,
// with a behavioural cache array and a delayed-ack memory model around the controller.
module tb_cache_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_din, cpu_dout;
   logic        cpu_ready;
   logic [31:0] cache_addr, cache_din, cache_dout;
   logic        cache_store, cache_edit, cache_invalid;
   logic        cache_hit, cache_valid, cache_dirty;
   logic [21:0] cache_tag;
   logic        mem_cs, mem_we;
   logic [31:0] mem_addr, mem_dout;
   logic [31:0] mem_din = 32'd0;
   logic        mem_ack = 1'b0;
`ifdef CACHE_CTRL_FLUSH_EN
   logic        flush_req;
   logic        flush_done;
`endif

   always #5 clk = ~clk;

   cache_ctrl dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout), .cpu_ready(cpu_ready),
      .cache_addr(cache_addr), .cache_store(cache_store), .cache_edit(cache_edit),
      .cache_invalid(cache_invalid), .cache_din(cache_din), .cache_hit(cache_hit),
      .cache_dout(cache_dout), .cache_valid(cache_valid), .cache_dirty(cache_dirty),
      .cache_tag(cache_tag),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
      .mem_din(mem_din), .mem_ack(mem_ack)
`ifdef CACHE_CTRL_FLUSH_EN
      , .flush_req(flush_req), .flush_done(flush_done)
`endif
   );

   // ---------------- cache datapath stand-in ----------------
   logic [31:0] cd [64][4];
   logic        cv [64];
   logic        cdty [64];
   logic [21:0] ct [64];
   logic [5:0]  cidx;
   logic [1:0]  cwrd;
   logic        clr_cache = 1'b1;

   assign cidx        = cache_addr[9:4];
   assign cwrd        = cache_addr[3:2];
   assign cache_hit   = cv[cidx] && (ct[cidx] == cache_addr[31:10]);
   assign cache_dout  = cd[cidx][cwrd];
   assign cache_valid = cv[cidx];
   assign cache_dirty = cdty[cidx];
   assign cache_tag   = ct[cidx];

   always @(posedge clk) begin
      if (clr_cache) begin
         for (int i = 0; i < 64; i++) begin
            cv[i]   <= 1'b0;
            cdty[i] <= 1'b0;
         end
      end else if (cache_store) begin
         cd[cidx][cwrd] <= cache_din;
         cv[cidx]       <= 1'b1;
         cdty[cidx]     <= 1'b0;
         ct[cidx]       <= cache_addr[31:10];
      end else if (cache_edit) begin
         cd[cidx][cwrd] <= cache_din;
         cdty[cidx]     <= 1'b1;
      end else if (cache_invalid) begin
         cv[cidx] <= 1'b0;
      end
   end

   // ---------------- reference model and scoreboard ----------------
   typedef struct {
      logic        we;
      logic [31:0] data;
      int          acks;
   } sb_t;

   sb_t         sb[$];
   logic [31:0] mem  [logic [31:0]];
   logic [31:0] refm [logic [31:0]];
   bit          res_v [64];
   bit          res_d [64];
   logic [27:0] res_line [64];
   int          cmps = 0;
   int          errs = 0;
   int          delay = 0;
   int          ack_total = 0;

   function automatic logic [31:0] rd_ref(input logic [31:0] a);
      if (refm.exists(a)) return refm[a];
      return a;
   endfunction

   function automatic logic [31:0] rd_mem(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a;
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmps++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   always @(posedge clk) begin
      if (rst && mem_ack) ack_total++;
   end

   // ---------------- monitor + memory model (negedge) ----------------
   int          ack_mark = 0;
   int          ack_wait = 0;
   int          wait_cyc = 0;
   bit          pend = 1'b0;
   logic [31:0] p_addr, p_dout;
   logic        p_we;

   always @(negedge clk) begin
      if (!rst) begin
         mem_ack  = 1'b0;
         ack_wait = 0;
         pend     = 1'b0;
         wait_cyc = 0;
         ack_mark = ack_total;
         sb.delete();
      end else begin
         if (cpu_ready) begin
            if (sb.size() == 0) begin
               cmps++; errs++;
               $display("FAIL unexpected cpu_ready: got 1, expected 0 (t=%0t)", $time);
            end else begin
               sb_t e;
               e = sb.pop_front();
               if (!e.we) chk("load data", cpu_dout, e.data);
               chk("miss ack count", 32'(ack_total - ack_mark), 32'(e.acks));
               ack_mark = ack_total;
            end
         end
         if (cpu_req && !cpu_ready) wait_cyc++;
         else wait_cyc = 0;
         if (wait_cyc == 200) begin
            cmps++; errs++;
            $display("FAIL request timeout: got no cpu_ready, expected one within 200 cycles");
         end
         if (mem_ack) begin
            mem_ack = 1'b0;
         end else if (mem_cs) begin
            if (pend) begin
               chk("mem_addr held", mem_addr, p_addr);
               chk("mem_we held", 32'(mem_we), 32'(p_we));
               if (p_we) chk("mem_dout held", mem_dout, p_dout);
            end
            if (ack_wait >= delay) begin
               mem_ack  = 1'b1;
               ack_wait = 0;
               pend     = 1'b0;
               if (mem_we) begin
                  chk("writeback data", mem_dout, rd_ref(mem_addr));
                  mem[mem_addr] = mem_dout;
               end else begin
                  mem_din = rd_mem(mem_addr);
               end
            end else begin
               ack_wait++;
               pend   = 1'b1;
               p_addr = mem_addr;
               p_we   = mem_we;
               p_dout = mem_dout;
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d);
      sb_t        e;
      logic [5:0] idx;
      bit         hit;
      int         n;
      idx = a[9:4];
      hit = res_v[idx] && (res_line[idx] == a[31:4]);
      if (hit) e.acks = 0;
      else if (res_v[idx] && res_d[idx]) e.acks = 8;
      else e.acks = 4;
      if (!hit) res_d[idx] = 1'b0;
      res_v[idx]    = 1'b1;
      res_line[idx] = a[31:4];
      if (we) begin
         res_d[idx] = 1'b1;
         refm[a]    = d;
      end
      e.we   = we;
      e.data = rd_ref(a);
      sb.push_back(e);
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
      n = 0;
      @(negedge clk);
      while (!cpu_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      cpu_req = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      int          base;
      int          n;
`ifdef CACHE_CTRL_FLUSH_EN
      flush_req = 1'b0;
`endif
      rst = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h14; cpu_din = 32'h5a5a_5a5a;
      for (int i = 0; i < 64; i++) begin
         res_v[i] = 1'b0; res_d[i] = 1'b0; res_line[i] = 28'd0;
      end
      repeat (3) @(negedge clk);
      chk("reset cpu_ready", 32'(cpu_ready), 32'd0);
      chk("reset mem_cs", 32'(mem_cs), 32'd0);
      chk("reset mem_we", 32'(mem_we), 32'd0);
      chk("reset cache_store", 32'(cache_store), 32'd0);
      chk("reset cache_edit", 32'(cache_edit), 32'd0);
      chk("reset cache_invalid", 32'(cache_invalid), 32'd0);
      chk("reset mem_addr", mem_addr, 32'd0);
      chk("reset cache_addr", cache_addr, 32'd0);
      chk("reset cache_din", cache_din, 32'd0);
      chk("reset cpu_dout", cpu_dout, 32'd0);
      chk("reset mem_dout", mem_dout, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1; cpu_req = 1'b0; clr_cache = 1'b0;

      do_req(1'b0, 32'h0000_0014, 32'd0);
      do_req(1'b0, 32'h0000_0018, 32'd0);
      do_req(1'b1, 32'h0000_0018, 32'h2222_2222);
      do_req(1'b0, 32'h0000_0018, 32'd0);
      do_req(1'b0, 32'h0000_0418, 32'd0);

      for (int k = 0; k < 300; k++) begin
         delay = $urandom_range(0, 3);
         a = 32'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2));
         do_req($urandom_range(0, 1) == 1, a, $urandom);
      end

      // abort a slow refill after its second word
      delay = 3;
      a = 32'h0000_1544;
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
      base = ack_total;
      n = 0;
      while (ack_total - base < 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("second fill ack reached", 32'(ack_total - base), 32'd2);
      rst = 1'b0;
      #1;
      chk("async abort mem_cs", 32'(mem_cs), 32'd0);
      chk("async abort cpu_ready", 32'(cpu_ready), 32'd0);
      chk("async abort mem_addr", mem_addr, 32'd0);
      cpu_req = 1'b0; clr_cache = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      refm = mem;
      for (int i = 0; i < 64; i++) begin
         res_v[i] = 1'b0; res_d[i] = 1'b0;
      end
      clr_cache = 1'b0; rst = 1'b1;
      do_req(1'b0, a, 32'd0);
      do_req(1'b0, 32'h0000_154c, 32'd0);
      delay = 0;
      do_req(1'b0, 32'h0000_0418, 32'd0);

      repeat (4) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end

endmodule
